// File: rtl/prog_loader_if.sv
// Host-link byte stream and shared-bus write port of the program loader.
`default_nettype none

interface prog_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        mar_we;
  logic        ram_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  in_data, in_valid, abort,
    output in_ready, bus_out, bus_oe, mar_we, ram_we, cpu_hold, busy, done, err
  );

  modport slave (
    output in_data, in_valid, abort,
    input  in_ready, bus_out, bus_oe, mar_we, ram_we, cpu_hold, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, address, length, data..., checksum -> MAR/RAM bus cycles.
`default_nettype none

module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LEN    = 3'd2,
    DATA   = 3'd3,
    SETMAR = 3'd4,
    WRITE  = 3'd5,
    CSUM   = 3'd6,
    FIN    = 3'd7
  } state_t;

  state_t     state;
  logic [7:0] addr;
  logic [7:0] data;
  logic [7:0] sum;
  logic [8:0] count;
  logic       err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= 8'h00;
      data  <= 8'h00;
      sum   <= 8'h00;
      count <= 9'd0;
      err   <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state <= IDLE;
      err   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_data == SYNC_BYTE) begin
            state <= ADDR;
            err   <= 1'b0;
          end
        end
        ADDR: begin
          if (bus.in_valid) begin
            addr  <= bus.in_data;
            state <= LEN;
          end
        end
        LEN: begin
          if (bus.in_valid) begin
            // A zero length byte encodes a full 256-byte page.
            count <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
            sum   <= 8'h00;
            state <= DATA;
          end
        end
        DATA: begin
          if (bus.in_valid) begin
            data  <= bus.in_data;
            sum   <= sum + bus.in_data;
            state <= SETMAR;
          end
        end
        SETMAR: state <= WRITE;
        WRITE: begin
          addr  <= addr + 8'd1;
          count <= count - 9'd1;
          state <= (count == 9'd1) ? CSUM : DATA;
        end
        CSUM: begin
          if (bus.in_valid) begin
            if (bus.in_data != sum) err <= 1'b1;
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are Moore-decoded so an asynchronous reset kills strobes immediately.
  assign bus.in_ready = (state == IDLE) || (state == ADDR) || (state == LEN) ||
                        (state == DATA) || (state == CSUM);
  assign bus.bus_oe   = (state == SETMAR) || (state == WRITE);
  assign bus.mar_we   = (state == SETMAR);
  assign bus.ram_we   = (state == WRITE);
  assign bus.bus_out  = (state == SETMAR) ? {8'h00, addr} :
                        (state == WRITE)  ? {8'h00, data} : 16'h0000;
  assign bus.cpu_hold = (state != IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIN);
  assign bus.err      = err;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: fixed frames from the test plan plus randomized frames.
`default_nettype none

module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus();
  prog_loader #(.SYNC_BYTE(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Bus-side observer: memory model plus protocol counters
  logic [7:0]  tb_ram [256];
  logic [7:0]  tb_mar = 8'h00;
  logic [15:0] writes [$];
  int          done_cnt = 0, done_at = 0, hold_cyc = 0, mar_cnt = 0, viol = 0;
  bit          prev_mar = 1'b0;

  always @(negedge clk) begin
    if (bus.cpu_hold) hold_cyc++;
    if (bus.done) begin done_cnt++; done_at = hold_cyc; end
    if ((bus.mar_we && bus.ram_we) || (bus.ram_we && !prev_mar) ||
        (!bus.bus_oe && (bus.mar_we || bus.ram_we || bus.bus_out != 16'h0)) ||
        bus.bus_out[15:8] != 8'h00)
      viol++;
    if (bus.mar_we) begin tb_mar = bus.bus_out[7:0]; mar_cnt++; end
    if (bus.ram_we) begin
      tb_ram[tb_mar] = bus.bus_out[7:0];
      writes.push_back({tb_mar, bus.bus_out[7:0]});
    end
    prev_mar = bus.mar_we;
  end

  // Reference frame and expected effects
  logic [7:0]  frm   [$];
  logic [15:0] exp_w [$];
  bit          exp_err;

  task automatic build(input logic [7:0] a, input int len, input bit rnd,
                       input logic [7:0] fill, input bit corrupt);
    int sum = 0;
    logic [7:0] d, c, ad;
    frm = {}; exp_w = {};
    frm.push_back(8'hA5); frm.push_back(a); frm.push_back(8'(len % 256));
    for (int i = 0; i < len; i++) begin
      d  = rnd ? 8'($urandom) : fill;
      ad = 8'((int'(a) + i) % 256);
      frm.push_back(d);
      exp_w.push_back({ad, d});
      sum += int'(d);
    end
    c = 8'(sum % 256);
    if (corrupt) c = c ^ 8'($urandom_range(1, 255));
    frm.push_back(c);
    exp_err = corrupt;
  endtask

  function automatic int write_diffs(int base);
    int n = 0;
    if (writes.size() - base != exp_w.size()) return 1000;
    foreach (exp_w[i]) if (writes[base + i] !== exp_w[i]) n++;
    return n;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (bus.in_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_byte timeout: in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic send_frame(input bit gaps);
    bit idle = 0;
    foreach (frm[i]) send_byte(frm[i], gaps);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 10 && !idle; n++) begin
      if (!bus.busy) idle = 1;
      else begin @(posedge clk); #1; end
    end
    if (!idle) begin
      tests++; fails++;
      $display("FAIL frame_end timeout: busy=%0b required 0", bus.busy);
    end
  endtask

  task automatic test_reset;
    logic [23:0] got;
    got = {bus.in_ready, bus.bus_oe, bus.mar_we, bus.ram_we, bus.cpu_hold,
           bus.busy, bus.done, bus.err, bus.bus_out};
    tests++;
    if (got !== 24'h800000) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 800000", got);
    end
  endtask

  task automatic test_normal;
    int wb = writes.size(), db = done_cnt, hb = hold_cyc, d;
    frm   = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    exp_w = '{16'h1001, 16'h1102, 16'h1203};
    send_frame(1'b0);
    d = write_diffs(wb);
    tests++; if (d !== 0) begin fails++; $display("FAIL normal_writes: diffs %0d required 0", d); end
    tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL normal_done: got %0d required 1", done_cnt - db); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL normal_err: got %0b required 0", bus.err); end
    tests++; if (hold_cyc - hb !== 13) begin fails++; $display("FAIL normal_hold_cycles: got %0d required 13", hold_cyc - hb); end
    tests++; if (done_at - hb !== 13) begin fails++; $display("FAIL normal_done_time: got %0d required 13", done_at - hb); end
    tests++;
    if ({tb_ram[8'h10], tb_ram[8'h11], tb_ram[8'h12]} !== 24'h010203) begin
      fails++;
      $display("FAIL normal_readback: got %h required 010203", {tb_ram[8'h10], tb_ram[8'h11], tb_ram[8'h12]});
    end
  endtask

  task automatic test_bad_csum;
    int wb = writes.size(), db = done_cnt, d;
    frm   = '{8'hA5, 8'h00, 8'h01, 8'h7F, 8'h00};
    exp_w = '{16'h007F};
    send_frame(1'b0);
    d = write_diffs(wb);
    tests++; if (d !== 0) begin fails++; $display("FAIL badcs_writes: diffs %0d required 0", d); end
    tests++; if (tb_ram[0] !== 8'h7F) begin fails++; $display("FAIL badcs_ram0: got %h required 7f", tb_ram[0]); end
    tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL badcs_done: got %0d required 1", done_cnt - db); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL badcs_err: got %0b required 1", bus.err); end
    build(8'h40, 2, 1'b1, 8'h00, 1'b0);
    send_byte(frm[0], 1'b0);
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL sync_clears_err: got %0b required 0", bus.err); end
    frm.pop_front();
    send_frame(1'b0);
  endtask

  task automatic test_wrap;
    int wb = writes.size(), d;
    build(8'hFE, 256, 1'b0, 8'h5A, 1'b0);
    send_frame(1'b0);
    d = write_diffs(wb);
    tests++; if (d !== 0) begin fails++; $display("FAIL wrap_writes: diffs %0d required 0", d); end
    tests++; if (writes.size() - wb !== 256) begin fails++; $display("FAIL wrap_count: got %0d required 256", writes.size() - wb); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL wrap_err: got %0b required 0", bus.err); end
  endtask

  task automatic test_garbage;
    int wb = writes.size(), mb = mar_cnt, d;
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b1); send_byte(8'h3C, 1'b1);
    tests++;
    if (mar_cnt - mb !== 0 || writes.size() - wb !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL garbage_ignored: mar %0d writes %0d busy %0b required 0 0 0",
               mar_cnt - mb, writes.size() - wb, bus.busy);
    end
    frm   = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    exp_w = '{16'h1001, 16'h1102, 16'h1203};
    send_frame(1'b1);
    d = write_diffs(wb);
    tests++; if (d !== 0) begin fails++; $display("FAIL garbage_writes: diffs %0d required 0", d); end
  endtask

  task automatic test_random;
    int wb, db, d, bad;
    for (int k = 0; k < 6; k++) begin
      wb = writes.size(); db = done_cnt; bad = 0;
      build(8'($urandom), $urandom_range(1, 12), 1'b1, 8'h00, $urandom_range(0, 2) == 0);
      send_frame(1'b1);
      d = write_diffs(wb);
      tests++; if (d !== 0) begin fails++; $display("FAIL rand%0d_writes: diffs %0d required 0", k, d); end
      tests++; if (bus.err !== exp_err) begin fails++; $display("FAIL rand%0d_err: got %0b required %0b", k, bus.err, exp_err); end
      tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL rand%0d_done: got %0d required 1", k, done_cnt - db); end
      foreach (exp_w[i]) if (tb_ram[exp_w[i][15:8]] !== exp_w[i][7:0]) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL rand%0d_readback: bad %0d required 0", k, bad); end
    end
  endtask

  task automatic test_abort;
    int wb = writes.size(), db = done_cnt;
    send_byte(8'hA5, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'hAA, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.ram_we !== 1'b1) begin fails++; $display("FAIL abort_in_write: ram_we %0b required 1", bus.ram_we); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    tests++;
    if ({bus.busy, bus.cpu_hold, bus.err} !== 3'b001) begin
      fails++;
      $display("FAIL abort_state: busy/hold/err %b required 001", {bus.busy, bus.cpu_hold, bus.err});
    end
    repeat (3) @(posedge clk); #1;
    tests++;
    if (done_cnt - db !== 0 || writes.size() - wb !== 1 || writes[wb] !== 16'h20AA) begin
      fails++;
      $display("FAIL abort_effects: done %0d writes %0d required 0 1 (20aa)", done_cnt - db, writes.size() - wb);
    end
  endtask

  task automatic test_abort_idle;
    bus.abort = 1'b1;
    send_byte(8'hA5, 1'b0);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.busy, bus.err} !== 2'b10) begin
      fails++;
      $display("FAIL abort_idle_ignored: busy/err %b required 10", {bus.busy, bus.err});
    end
    @(posedge clk); #1;
    bus.abort = 1'b0;
    tests++;
    if ({bus.busy, bus.err} !== 2'b01) begin
      fails++;
      $display("FAIL abort_in_addr: busy/err %b required 01", {bus.busy, bus.err});
    end
  endtask

  task automatic test_rst_mid;
    int wb = writes.size();
    logic [23:0] got;
    send_byte(8'hA5, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h77, 1'b0);
    tests++; if (bus.mar_we !== 1'b1) begin fails++; $display("FAIL rst_setup: mar_we %0b required 1", bus.mar_we); end
    #1 rst = 1'b1;
    #1;
    got = {bus.in_ready, bus.bus_oe, bus.mar_we, bus.ram_we, bus.cpu_hold,
           bus.busy, bus.done, bus.err, bus.bus_out};
    tests++; if (got !== 24'h800000) begin fails++; $display("FAIL rst_async_outputs: got %h required 800000", got); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    tests++; if (writes.size() - wb !== 0) begin fails++; $display("FAIL rst_no_write: got %0d required 0", writes.size() - wb); end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_normal;
    test_bad_csum;
    test_wrap;
    test_garbage;
    test_random;
    test_abort;
    test_abort_idle;
    test_rst_mid;
    tests++;
    if (viol !== 0) begin fails++; $display("FAIL bus_protocol: violations %0d required 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
